pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard detection, operand forwarding and memory-wait FSM for a 5-stage pipeline.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rf_ra0_id,
    input  logic [4:0]  rf_ra1_id,
    input  logic [4:0]  rf_ra0_ex,
    input  logic [4:0]  rf_ra1_ex,
    input  logic [4:0]  rf_wa_ex,
    input  logic        rf_we_ex,
    input  logic [1:0]  rf_wd_sel_ex,
    input  logic [4:0]  rf_wa_mem,
    input  logic        rf_we_mem,
    input  logic [4:0]  rf_wa_wb,
    input  logic        rf_we_wb,
    input  logic        br_taken_ex,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_mem_wb,
    output logic        pipe_en,
    output logic [1:0]  fwd0_sel,
    output logic [1:0]  fwd1_sel,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state,
    output logic        timeout_err
);
    typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, HALT = 2'd2} state_t;
    state_t st;
    logic [3:0] wait_cnt;
    logic halt, mw, lu, br_flush, any_stall;
    // While rst is asserted the outputs behave as in RUN, even if the register still holds HALT.
    assign halt = (st == HALT) && !rst;
    assign mw = dmem_req && !dmem_ack;
    assign lu = rf_we_ex && rf_wd_sel_ex == 2'b10 && rf_wa_ex != 5'd0 &&
                (rf_ra0_id == rf_wa_ex || rf_ra1_id == rf_wa_ex);
    assign br_flush = !halt && !mw && br_taken_ex;
    assign pipe_en = !halt;
    assign stall_pc = !halt && (mw || (!br_taken_ex && lu));
    assign stall_if_id = stall_pc;
    assign stall_id_ex = !halt && mw;
    assign stall_ex_mem = stall_id_ex;
    assign flush_mem_wb = stall_id_ex;
    assign flush_if_id = br_flush;
    assign flush_id_ex = !halt && !mw && (br_taken_ex || lu);
    assign any_stall = stall_pc;
    assign fwd0_sel = (rf_we_mem && rf_wa_mem != 5'd0 && rf_wa_mem == rf_ra0_ex) ? 2'b01 :
                      (rf_we_wb && rf_wa_wb != 5'd0 && rf_wa_wb == rf_ra0_ex) ? 2'b10 : 2'b00;
    assign fwd1_sel = (rf_we_mem && rf_wa_mem != 5'd0 && rf_wa_mem == rf_ra1_ex) ? 2'b01 :
                      (rf_we_wb && rf_wa_wb != 5'd0 && rf_wa_wb == rf_ra1_ex) ? 2'b10 : 2'b00;
    assign state = st;
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= RUN;
            wait_cnt <= 4'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (any_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (br_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            case (st)
                RUN: begin
                    wait_cnt <= 4'd0;
                    if (mw) st <= WAIT;
                end
                WAIT: begin
                    if (!mw) begin
                        st <= RUN;
                        wait_cnt <= 4'd0;
                    end else if (wait_cnt == 4'd15) begin
                        st <= HALT;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                HALT: st <= HALT;
                default: st <= RUN;
            endcase
        end
    end
endmodule
